// File: rtl/hevc_sched_pkg.sv
// Shared scheduling types and the rotating-priority pick used by multi-flux actors.
package hevc_sched_pkg;

    typedef enum logic {IDLE, OWN} sched_state_t;

    // Widest flux count the generic pick function handles.
    localparam int unsigned RR_MAX_FLUX = 32;
    localparam int unsigned RR_MAX_TAG  = 5;

    typedef struct packed {
        logic                  found;
        logic [RR_MAX_TAG-1:0] idx;
    } rr_pick_t;

    // First set bit of mask at or after ptr, wrapping at nflux-1 back to 0.
    function automatic rr_pick_t rr_pick(input logic [RR_MAX_FLUX-1:0] mask,
                                         input int unsigned nflux,
                                         input int unsigned ptr);
        rr_pick_t    res;
        int unsigned idx;
        res = '0;
        for (int unsigned k = 0; k < RR_MAX_FLUX; k++) begin
            idx = ptr + k;
            if (idx >= nflux) begin
                idx = idx - nflux;
            end
            if (k < nflux && !res.found && mask[idx[RR_MAX_TAG-1:0]]) begin
                res.found = 1'b1;
                res.idx   = idx[RR_MAX_TAG-1:0];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/rr_pick_comb.sv
// Combinational rotating-priority finder: first candidate at or after ptr.
module rr_pick_comb
    import hevc_sched_pkg::*;
#(
    parameter int unsigned FLUX      = 2,
    parameter int unsigned TAG_WIDTH = 1
) (
    input  logic [FLUX-1:0]      mask,
    input  logic [TAG_WIDTH-1:0] ptr,
    output logic                 found,
    output logic [TAG_WIDTH-1:0] idx
);

    logic [RR_MAX_FLUX-1:0] mask_ext;
    rr_pick_t               res;
    logic                   unused_pick_bits;

    // Widen the mask to the package width and narrow the result back to TAG_WIDTH.
    always_comb begin
        mask_ext               = '0;
        mask_ext[FLUX-1:0]     = mask;
        res                    = rr_pick(mask_ext, FLUX, 32'(ptr));
        found                  = res.found;
        idx                    = res.idx[TAG_WIDTH-1:0];
        unused_pick_bits       = ^res.idx;
    end

endmodule

// File: rtl/flux_rr_scheduler.sv
// Burst-ownership round-robin scheduler sharing one actor between FLUX input FIFOs.
module flux_rr_scheduler
    import hevc_sched_pkg::*;
#(
    parameter int unsigned FLUX         = 2,
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned BURST        = 8,
    parameter int unsigned STARVE_LIMIT = 4,
    localparam int unsigned TAG_WIDTH   = (FLUX > 1) ? $clog2(FLUX) : 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [FLUX-1:0]            flux_enable,
    input  logic [FLUX-1:0]            in_empty,
    input  logic [FLUX*DATA_WIDTH-1:0] in_dout,
    output logic [FLUX-1:0]            in_read,
    output logic                       out_empty,
    output logic [DATA_WIDTH-1:0]      out_dout,
    input  logic                       out_read,
    output logic [TAG_WIDTH-1:0]       out_tag,
    output logic                       busy
);

    localparam int unsigned CNT_WIDTH = $clog2(BURST + 1);
    localparam int unsigned STV_WIDTH = $clog2(STARVE_LIMIT + 1);

    sched_state_t         state_q;
    logic [TAG_WIDTH-1:0] grant_q;
    logic [TAG_WIDTH-1:0] rr_ptr_q;
    logic [CNT_WIDTH-1:0] burst_cnt_q;
    logic [STV_WIDTH-1:0] starve_cnt_q;

    logic [FLUX-1:0]       cand;
    logic                  pick_found;
    logic [TAG_WIDTH-1:0]  pick_idx;
    logic                  g_empty;
    logic                  g_en;
    logic [DATA_WIDTH-1:0] g_dout;
    logic                  accept;
    logic [TAG_WIDTH-1:0]  next_ptr;

    assign cand = flux_enable & ~in_empty;

    rr_pick_comb #(
        .FLUX      (FLUX),
        .TAG_WIDTH (TAG_WIDTH)
    ) u_pick (
        .mask  (cand),
        .ptr   (rr_ptr_q),
        .found (pick_found),
        .idx   (pick_idx)
    );

    // Select status and head of the currently granted flux.
    always_comb begin
        g_empty = 1'b1;
        g_en    = 1'b0;
        g_dout  = '0;
        for (int i = 0; i < FLUX; i++) begin
            if (grant_q == TAG_WIDTH'(i)) begin
                g_empty = in_empty[i];
                g_en    = flux_enable[i];
                g_dout  = in_dout[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Actor-facing read port; pops are gated by OWN so reset or IDLE never pops.
    always_comb begin
        out_empty = 1'b1;
        out_dout  = '0;
        in_read   = '0;
        accept    = 1'b0;
        if (state_q == OWN) begin
            out_empty = g_empty | ~g_en;
            out_dout  = g_dout;
            accept    = out_read & ~out_empty;
            for (int i = 0; i < FLUX; i++) begin
                if (grant_q == TAG_WIDTH'(i)) begin
                    in_read[i] = accept;
                end
            end
        end
    end

    assign out_tag  = grant_q;
    assign busy     = (state_q == OWN);
    assign next_ptr = (grant_q == TAG_WIDTH'(FLUX - 1)) ? '0 : grant_q + TAG_WIDTH'(1);

    // Grant FSM: arbitrate in IDLE, hold the flux in OWN until a release condition.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            grant_q      <= '0;
            rr_ptr_q     <= '0;
            burst_cnt_q  <= '0;
            starve_cnt_q <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (pick_found) begin
                        grant_q      <= pick_idx;
                        burst_cnt_q  <= '0;
                        starve_cnt_q <= '0;
                        state_q      <= OWN;
                    end
                end
                OWN: begin
                    if (!g_en) begin
                        state_q  <= IDLE;
                        rr_ptr_q <= next_ptr;
                    end else if (accept) begin
                        burst_cnt_q  <= burst_cnt_q + CNT_WIDTH'(1);
                        starve_cnt_q <= '0;
                        if (burst_cnt_q == CNT_WIDTH'(BURST - 1)) begin
                            state_q  <= IDLE;
                            rr_ptr_q <= next_ptr;
                        end
                    end else if (g_empty) begin
                        if (starve_cnt_q == STV_WIDTH'(STARVE_LIMIT - 1)) begin
                            state_q  <= IDLE;
                            rr_ptr_q <= next_ptr;
                        end else begin
                            starve_cnt_q <= starve_cnt_q + STV_WIDTH'(1);
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_flux_rr_scheduler.sv
// Bench for flux_rr_scheduler: directed scenarios plus randomized run against a reference model.
module tb_flux_rr_scheduler;

    localparam int unsigned FLUX   = 2;
    localparam int unsigned DW     = 32;
    localparam int unsigned BURST  = 8;
    localparam int unsigned STARVE = 4;
    localparam int unsigned TW     = 1;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic [FLUX-1:0]      flux_enable;
    logic [FLUX-1:0]      in_empty;
    logic [FLUX*DW-1:0]   in_dout;
    logic [FLUX-1:0]      in_read;
    logic                 out_empty;
    logic [DW-1:0]        out_dout;
    logic                 out_read;
    logic [TW-1:0]        out_tag;
    logic                 busy;

    always #5 clk = ~clk;

    flux_rr_scheduler #(
        .FLUX         (FLUX),
        .DATA_WIDTH   (DW),
        .BURST        (BURST),
        .STARVE_LIMIT (STARVE)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .flux_enable (flux_enable),
        .in_empty    (in_empty),
        .in_dout     (in_dout),
        .in_read     (in_read),
        .out_empty   (out_empty),
        .out_dout    (out_dout),
        .out_read    (out_read),
        .out_tag     (out_tag),
        .busy        (busy)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model: owner -1 means nobody holds the actor.
    int m_owner, m_ptr, m_pops, m_dry;

    logic            exp_empty, exp_busy;
    logic [FLUX-1:0] exp_read;
    logic [DW-1:0]   exp_dout;
    logic [TW-1:0]   exp_tag;

    task automatic model_reset();
        m_owner = -1;
        m_ptr   = 0;
        m_pops  = 0;
        m_dry   = 0;
    endtask

    task automatic model_eval();
        logic [FLUX-1:0] oh;
        logic            avail;
        if (m_owner < 0) begin
            exp_empty = 1'b1;
            exp_busy  = 1'b0;
            exp_read  = '0;
            exp_dout  = '0;
            exp_tag   = '0;
        end else begin
            oh        = FLUX'(1) << m_owner;
            avail     = (|(flux_enable & oh)) && !(|(in_empty & oh));
            exp_empty = !avail;
            exp_busy  = 1'b1;
            exp_read  = (out_read && avail) ? oh : '0;
            exp_dout  = DW'(in_dout >> (m_owner * DW));
            exp_tag   = TW'(m_owner);
        end
    endtask

    task automatic model_step();
        logic [FLUX-1:0] oh;
        bit              rel;
        int              c;
        rel = 0;
        if (m_owner < 0) begin
            for (int k = 0; k < FLUX; k++) begin
                c  = (m_ptr + k) % FLUX;
                oh = FLUX'(1) << c;
                if (m_owner < 0 && (|(flux_enable & oh)) && !(|(in_empty & oh))) begin
                    m_owner = c;
                    m_pops  = 0;
                    m_dry   = 0;
                end
            end
        end else begin
            oh = FLUX'(1) << m_owner;
            if (!(|(flux_enable & oh))) begin
                rel = 1;
            end else if (out_read && !(|(in_empty & oh))) begin
                m_pops++;
                m_dry = 0;
                if (m_pops == int'(BURST)) rel = 1;
            end else if (|(in_empty & oh)) begin
                m_dry++;
                if (m_dry == int'(STARVE)) rel = 1;
            end
            if (rel) begin
                m_ptr   = (m_owner + 1) % FLUX;
                m_owner = -1;
            end
        end
    endtask

    task automatic set_in(input logic [FLUX-1:0] en, input logic [FLUX-1:0] emp,
                          input logic rd);
        flux_enable = en;
        in_empty    = emp;
        out_read    = rd;
        for (int i = 0; i < FLUX; i++) in_dout[i*DW +: DW] = $urandom();
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst_n) model_step();
        #1;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        #2;
        n_cmp++;
        if (in_read !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_in_read: got %b want 00", in_read);
        end
        n_cmp++;
        if (out_empty !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_out_empty: got %b want 1", out_empty);
        end
        n_cmp++;
        if (out_dout !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_out_dout: got %h want 0", out_dout);
        end
        n_cmp++;
        if (out_tag !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_out_tag: got %b want 0", out_tag);
        end
        n_cmp++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_busy: got %b want 0", busy);
        end
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Bubble, 8 pops of flux0, bubble, then flux1.
    task automatic test_basic_burst();
        for (int c = 0; c <= 10; c++) begin
            set_in(2'b11, 2'b00, 1'b1);
            @(negedge clk);
            n_cmp++;
            if (c == 0 || c == 9) begin
                if (out_empty !== 1'b1 || in_read !== 2'b00 || busy !== 1'b0) begin
                    n_fail++;
                    $display("FAIL basic_bubble c%0d: got empty=%b read=%b busy=%b want 1/00/0",
                             c, out_empty, in_read, busy);
                end
            end else if (c < 9) begin
                if (in_read !== 2'b01 || out_tag !== 1'b0 || busy !== 1'b1) begin
                    n_fail++;
                    $display("FAIL basic_pop0 c%0d: got read=%b tag=%b busy=%b want 01/0/1",
                             c, in_read, out_tag, busy);
                end
            end else begin
                if (in_read !== 2'b10 || out_tag !== 1'b1) begin
                    n_fail++;
                    $display("FAIL basic_pop1 c%0d: got read=%b tag=%b want 10/1",
                             c, in_read, out_tag);
                end
            end
            tick();
        end
    endtask

    // Both full, reads always: 4 bursts of 8 alternating 0,1,0,1 in 36 cycles.
    task automatic test_alternate();
        int pops0 = 0, pops1 = 0, run = 0, extra0 = 0, extra1 = 0;
        int order[$];
        int runs[$];
        apply_reset();
        for (int c = 0; c < 36; c++) begin
            set_in(2'b11, 2'b00, 1'b1);
            @(negedge clk);
            if (in_read != 2'b00) begin
                if (run == 0) order.push_back(int'(out_tag));
                run++;
                if (in_read == 2'b01) pops0++;
                else if (in_read == 2'b10) pops1++;
            end else if (run != 0) begin
                runs.push_back(run);
                run = 0;
            end
            tick();
        end
        if (run != 0) runs.push_back(run);
        n_cmp++;
        if (pops0 != 16 || pops1 != 16) begin
            n_fail++;
            $display("FAIL alt_pops: got %0d/%0d want 16/16", pops0, pops1);
        end
        n_cmp++;
        if (order.size() != 4 || runs.size() != 4) begin
            n_fail++;
            $display("FAIL alt_bursts: got %0d grants %0d runs want 4/4", order.size(), runs.size());
        end
        for (int i = 0; i < 4; i++) begin
            if (i < order.size() && i < runs.size()) begin
                n_cmp++;
                if (order[i] != i % 2 || runs[i] != 8) begin
                    n_fail++;
                    $display("FAIL alt_burst%0d: got flux %0d len %0d want flux %0d len 8",
                             i, order[i], runs[i], i % 2);
                end
            end
        end
        // Fifth grant: one bubble then pops of flux0 in the remaining cycles.
        for (int c = 0; c < 4; c++) begin
            set_in(2'b11, 2'b00, 1'b1);
            @(negedge clk);
            if (in_read == 2'b01) extra0++;
            if (in_read == 2'b10) extra1++;
            tick();
        end
        n_cmp++;
        if (extra0 != 3 || extra1 != 0) begin
            n_fail++;
            $display("FAIL alt_fifth: got pops %0d/%0d want 3/0", extra0, extra1);
        end
    endtask

    // Flux0 dries up after 3 pops: 4 starved cycles, release, rr_ptr moves to flux1.
    task automatic test_starve();
        apply_reset();
        for (int c = 0; c <= 9; c++) begin
            set_in(2'b11, (c >= 4 && c <= 7) ? 2'b01 : 2'b00, 1'b1);
            @(negedge clk);
            if (c >= 1 && c <= 3) begin
                n_cmp++;
                if (in_read !== 2'b01) begin
                    n_fail++;
                    $display("FAIL starve_pop c%0d: got %b want 01", c, in_read);
                end
            end else if (c >= 4 && c <= 7) begin
                n_cmp++;
                if (busy !== 1'b1 || out_empty !== 1'b1 || in_read !== 2'b00) begin
                    n_fail++;
                    $display("FAIL starve_hold c%0d: got busy=%b empty=%b read=%b want 1/1/00",
                             c, busy, out_empty, in_read);
                end
            end else if (c == 8) begin
                n_cmp++;
                if (busy !== 1'b0) begin
                    n_fail++;
                    $display("FAIL starve_release: got busy=%b want 0", busy);
                end
            end else if (c == 9) begin
                n_cmp++;
                if (in_read !== 2'b10 || out_tag !== 1'b1) begin
                    n_fail++;
                    $display("FAIL starve_next: got read=%b tag=%b want 10/1", in_read, out_tag);
                end
            end
            tick();
        end
    endtask

    // Flux1 disabled: only flux0, bubble every 9th cycle.
    task automatic test_disabled_flux();
        int pops0 = 0, pops1 = 0;
        bit bubble;
        apply_reset();
        for (int c = 0; c < 30; c++) begin
            set_in(2'b01, 2'b00, 1'b1);
            @(negedge clk);
            bubble = (c % 9 == 0);
            n_cmp++;
            if ((in_read == 2'b00) != bubble || (busy && out_tag !== 1'b0)) begin
                n_fail++;
                $display("FAIL dis_cycle c%0d: got read=%b tag=%b want bubble=%0d tag 0",
                         c, in_read, out_tag, bubble);
            end
            if (in_read[0]) pops0++;
            if (in_read[1]) pops1++;
            tick();
        end
        n_cmp++;
        if (pops0 != 26 || pops1 != 0) begin
            n_fail++;
            $display("FAIL dis_pops: got %0d/%0d want 26/0", pops0, pops1);
        end
    endtask

    // Disable flux0 after 2 pops: masked cycle, release, flux1 next.
    task automatic test_enable_drop();
        apply_reset();
        for (int c = 0; c <= 5; c++) begin
            set_in((c == 3) ? 2'b10 : 2'b11, 2'b00, 1'b1);
            @(negedge clk);
            if (c == 1 || c == 2) begin
                n_cmp++;
                if (in_read !== 2'b01) begin
                    n_fail++;
                    $display("FAIL drop_pop c%0d: got %b want 01", c, in_read);
                end
            end else if (c == 3) begin
                n_cmp++;
                if (in_read !== 2'b00 || out_empty !== 1'b1 || busy !== 1'b1) begin
                    n_fail++;
                    $display("FAIL drop_mask: got read=%b empty=%b busy=%b want 00/1/1",
                             in_read, out_empty, busy);
                end
            end else if (c == 4) begin
                n_cmp++;
                if (busy !== 1'b0 || out_empty !== 1'b1) begin
                    n_fail++;
                    $display("FAIL drop_release: got busy=%b empty=%b want 0/1", busy, out_empty);
                end
            end else if (c == 5) begin
                n_cmp++;
                if (in_read !== 2'b10 || out_tag !== 1'b1) begin
                    n_fail++;
                    $display("FAIL drop_next: got read=%b tag=%b want 10/1", in_read, out_tag);
                end
            end
            tick();
        end
    endtask

    // Async reset with burst_cnt=5, then a fresh full burst of flux0.
    task automatic test_reset_mid_burst();
        int pops0 = 0;
        apply_reset();
        for (int c = 0; c <= 5; c++) begin
            set_in(2'b11, 2'b00, 1'b1);
            tick();
        end
        set_in(2'b11, 2'b00, 1'b1);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        n_cmp++;
        if (in_read !== 2'b00 || out_empty !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL rstmid_now: got read=%b empty=%b busy=%b want 00/1/0",
                     in_read, out_empty, busy);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int c = 0; c <= 9; c++) begin
            set_in(2'b11, 2'b00, 1'b1);
            @(negedge clk);
            if (c == 0 || c == 9) begin
                n_cmp++;
                if (out_empty !== 1'b1 || in_read !== 2'b00) begin
                    n_fail++;
                    $display("FAIL rstmid_bubble c%0d: got empty=%b read=%b want 1/00",
                             c, out_empty, in_read);
                end
            end else if (in_read == 2'b01 && out_tag == 1'b0) begin
                pops0++;
            end
            tick();
        end
        n_cmp++;
        if (pops0 != 8) begin
            n_fail++;
            $display("FAIL rstmid_burst: got %0d pops of flux0 want 8", pops0);
        end
    endtask

    // Sticky random enables/empties and random reads, checked cycle by cycle.
    task automatic test_random();
        logic [FLUX-1:0] en  = 2'b11;
        logic [FLUX-1:0] emp = 2'b00;
        logic            rd;
        apply_reset();
        for (int cyc = 0; cyc < 1500; cyc++) begin
            for (int i = 0; i < FLUX; i++) begin
                if ($urandom_range(0, 4) == 0) emp = emp ^ (FLUX'(1) << i);
                if ($urandom_range(0, 39) == 0) en = en ^ (FLUX'(1) << i);
            end
            rd = ($urandom_range(0, 3) != 0);
            set_in(en, emp, rd);
            @(negedge clk);
            model_eval();
            n_cmp++;
            if (in_read !== exp_read) begin
                n_fail++;
                $display("FAIL rnd_in_read cyc%0d: got %b want %b", cyc, in_read, exp_read);
            end
            n_cmp++;
            if (out_empty !== exp_empty) begin
                n_fail++;
                $display("FAIL rnd_out_empty cyc%0d: got %b want %b", cyc, out_empty, exp_empty);
            end
            n_cmp++;
            if (busy !== exp_busy) begin
                n_fail++;
                $display("FAIL rnd_busy cyc%0d: got %b want %b", cyc, busy, exp_busy);
            end
            if (exp_busy) begin
                n_cmp++;
                if (out_tag !== exp_tag) begin
                    n_fail++;
                    $display("FAIL rnd_out_tag cyc%0d: got %b want %b", cyc, out_tag, exp_tag);
                end
            end
            if (!exp_empty || !exp_busy) begin
                n_cmp++;
                if (out_dout !== exp_dout) begin
                    n_fail++;
                    $display("FAIL rnd_out_dout cyc%0d: got %h want %h", cyc, out_dout, exp_dout);
                end
            end
            tick();
        end
    endtask

    initial begin
        rst_n = 1'b0;
        set_in(2'b11, 2'b00, 1'b1);
        model_reset();
        test_reset();
        test_basic_burst();
        test_alternate();
        test_starve();
        test_disabled_flux();
        test_enable_drop();
        test_reset_mid_burst();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
